// File: rtl/max_pool_2x2.sv
// max_pool_2x2: streaming 2x2 stride-2 pooling over a raster pixel stream.
// Define POOL_AVG_EN to compute truncated averages instead of maxima.
module max_pool_2x2 #(
    parameter int PIXEL_WIDTH   = 8,
    parameter int BUFFER_LENGTH = 2000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [PIXEL_WIDTH-1:0]           in_pixel,
    input  logic                             valid_in,
    input  logic [$clog2(BUFFER_LENGTH)-1:0] frame_column_size,
    input  logic [$clog2(BUFFER_LENGTH)-1:0] frame_row_size,
    output logic [PIXEL_WIDTH-1:0]           pool_out,
    output logic                             valid_out,
    output logic                             frame_done,
    output logic [$clog2(BUFFER_LENGTH)-1:0] out_column_size,
    output logic [$clog2(BUFFER_LENGTH)-1:0] out_row_size
);
    localparam int SW    = $clog2(BUFFER_LENGTH);
    localparam int DEPTH = BUFFER_LENGTH / 2;
    localparam int AW    = $clog2(DEPTH);
`ifdef POOL_AVG_EN
    localparam int LW = PIXEL_WIDTH + 1;
`else
    localparam int LW = PIXEL_WIDTH;
`endif
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EVEN = 2'd1;
    localparam logic [1:0] S_ODD  = 2'd2;

    logic [LW-1:0]          line_buf [DEPTH];
    logic [1:0]             state_q, state_d;
    logic [SW-1:0]          col_q, col_d, row_q, row_d;
    logic [SW-1:0]          cols_q, cols_d, rows_q, rows_d;
    logic [SW-1:0]          oc_q, oc_d, or_q, or_d;
    logic [PIXEL_WIDTH-1:0] pair_q, pair_d, pool_q, pool_d;
    logic                   valid_out_q, valid_out_d, frame_done_q, frame_done_d;
    logic [SW-1:0]          cols_sel, rows_sel, cols_eff, rows_eff;
    logic                   idle, odd_col, odd_row, last_col, last_row, buf_we;
    logic [AW-1:0]          buf_idx;
    logic [LW-1:0]          h_val, buf_rd;
    logic [PIXEL_WIDTH-1:0] pool_val;

    assign idle     = state_q == S_IDLE;
    assign odd_col  = col_q[0];
    assign odd_row  = state_q == S_ODD;
    // sizes are sampled live on a frame's first pixel, otherwise the latched copy
    assign cols_sel = idle ? frame_column_size : cols_q;
    assign rows_sel = idle ? frame_row_size : rows_q;
    assign cols_eff = (cols_sel == '0) ? SW'(1) : cols_sel;
    assign rows_eff = (rows_sel == '0) ? SW'(1) : rows_sel;
    assign last_col = col_q == cols_eff - SW'(1);
    assign last_row = row_q == rows_eff - SW'(1);
    assign buf_idx  = col_q[AW:1];
    assign buf_rd   = line_buf[buf_idx];

`ifdef POOL_AVG_EN
    assign h_val    = {1'b0, pair_q} + {1'b0, in_pixel};
    assign pool_val = PIXEL_WIDTH'(({1'b0, buf_rd} + {1'b0, h_val}) >> 2);
`else
    assign h_val    = (in_pixel > pair_q) ? in_pixel : pair_q;
    assign pool_val = (buf_rd > h_val) ? buf_rd : h_val;
`endif

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        cols_d       = cols_q;
        rows_d       = rows_q;
        oc_d         = oc_q;
        or_d         = or_q;
        pair_d       = pair_q;
        pool_d       = pool_q;
        valid_out_d  = 1'b0;
        frame_done_d = 1'b0;
        buf_we       = 1'b0;
        if (valid_in) begin
            if (idle) begin
                cols_d = frame_column_size;
                rows_d = frame_row_size;
                oc_d   = frame_column_size >> 1;
                or_d   = frame_row_size >> 1;
            end
            pair_d       = odd_col ? pair_q : in_pixel;
            buf_we       = odd_col && !odd_row;
            valid_out_d  = odd_col && odd_row;
            pool_d       = valid_out_d ? pool_val : pool_q;
            frame_done_d = last_col && last_row;
            col_d        = last_col ? '0 : col_q + SW'(1);
            row_d        = last_col ? (last_row ? '0 : row_q + SW'(1)) : row_q;
            state_d      = frame_done_d ? S_IDLE :
                           last_col ? (odd_row ? S_EVEN : S_ODD) :
                           (odd_row ? S_ODD : S_EVEN);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            cols_q       <= '0;
            rows_q       <= '0;
            oc_q         <= '0;
            or_q         <= '0;
            pair_q       <= '0;
            pool_q       <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            cols_q       <= cols_d;
            rows_q       <= rows_d;
            oc_q         <= oc_d;
            or_q         <= or_d;
            pair_q       <= pair_d;
            pool_q       <= pool_d;
            valid_out_q  <= valid_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) line_buf[buf_idx] <= h_val;
    end

    assign pool_out        = pool_q;
    assign valid_out       = valid_out_q;
    assign frame_done      = frame_done_q;
    assign out_column_size = oc_q;
    assign out_row_size    = or_q;
endmodule

// File: tb/tb_max_pool_2x2.sv
// tb_max_pool_2x2: table-driven frames with hand-computed pooled outputs,
// plus hand-written reset checks and a mid-frame reset sequence.
module tb_max_pool_2x2;
`ifdef POOL_AVG_EN
    localparam bit AVG = 1'b1;
`else
    localparam bit AVG = 1'b0;
`endif
    localparam int NV = 8;

    typedef struct {
        int cols, rows, pat, gap, b2b, n;
        int val[4];
        int idx[4];
        int oc, orr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_pixel = '0;
    logic        valid_in = 1'b0;
    logic [10:0] frame_column_size = '0, frame_row_size = '0;
    logic [7:0]  pool_out;
    logic        valid_out, frame_done;
    logic [10:0] out_column_size, out_row_size;

    max_pool_2x2 dut (
        .clk(clk), .rst(rst), .in_pixel(in_pixel), .valid_in(valid_in),
        .frame_column_size(frame_column_size), .frame_row_size(frame_row_size),
        .pool_out(pool_out), .valid_out(valid_out), .frame_done(frame_done),
        .out_column_size(out_column_size), .out_row_size(out_row_size)
    );

    always #5 clk = ~clk;

    vec_t vec [NV];
    int   n_cmp = 0, n_err = 0;
    int   cur_idx = 0, edge_idx = 0;
    int   got_val[$], got_idx[$], got_fd[$], exp_val[$], exp_idx[$], exp_fd[$];

    always @(posedge clk) if (valid_in) edge_idx <= cur_idx;

    always @(negedge clk) begin
        if (!rst) begin
            if (valid_out) begin
                got_val.push_back(int'(pool_out));
                got_idx.push_back(edge_idx);
            end
            if (frame_done) got_fd.push_back(edge_idx);
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic set_vec(input int i, input int c, input int r, input int p, input int g,
                           input int b, input int n, input int v0, input int v1, input int v2,
                           input int v3, input int i0, input int i1, input int i2, input int i3);
        vec[i].cols = c; vec[i].rows = r; vec[i].pat = p; vec[i].gap = g; vec[i].b2b = b;
        vec[i].n = n; vec[i].oc = c / 2; vec[i].orr = r / 2;
        vec[i].val[0] = v0; vec[i].val[1] = v1; vec[i].val[2] = v2; vec[i].val[3] = v3;
        vec[i].idx[0] = i0; vec[i].idx[1] = i1; vec[i].idx[2] = i2; vec[i].idx[3] = i3;
    endtask

    task automatic expect_frame(input int v);
        for (int k = 0; k < vec[v].n; k++) begin
            exp_val.push_back(vec[v].val[k]);
            exp_idx.push_back(vec[v].idx[k]);
        end
        exp_fd.push_back(vec[v].cols * vec[v].rows - 1);
    endtask

    task automatic send_frame(input int c, input int r, input int p, input int g, input int npix);
        for (int i = 0; i < npix; i++) begin
            valid_in = 1'b1;
            cur_idx  = i;
            in_pixel = (p == 0) ? 8'(i) : (p == 1) ? 8'd255 : 8'(15 - i);
            frame_column_size = (i == 0) ? 11'(c) : 11'd7;
            frame_row_size    = (i == 0) ? 11'(r) : 11'd9;
            @(posedge clk); #1;
            valid_in = 1'b0;
            if (g != 0 && i < npix - 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic compare(input int oc, input int orr);
        int m;
        check("out_count", got_val.size(), exp_val.size());
        m = (got_val.size() < exp_val.size()) ? got_val.size() : exp_val.size();
        for (int k = 0; k < m; k++) begin
            check($sformatf("pool_out[%0d]", k), got_val[k], exp_val[k]);
            check($sformatf("out_latency[%0d]", k), got_idx[k], exp_idx[k]);
        end
        check("frame_done_count", got_fd.size(), exp_fd.size());
        m = (got_fd.size() < exp_fd.size()) ? got_fd.size() : exp_fd.size();
        for (int k = 0; k < m; k++) check($sformatf("frame_done_at[%0d]", k), got_fd[k], exp_fd[k]);
        check("out_column_size", int'(out_column_size), oc);
        check("out_row_size", int'(out_row_size), orr);
        got_val.delete(); got_idx.delete(); got_fd.delete();
        exp_val.delete(); exp_idx.delete(); exp_fd.delete();
    endtask

    initial begin
        set_vec(0, 4, 4, 0, 0, 0, 4, AVG ? 2 : 5, AVG ? 4 : 7, AVG ? 10 : 13, AVG ? 12 : 15, 5, 7, 13, 15);
        set_vec(1, 5, 3, 0, 0, 0, 2, AVG ? 3 : 6, AVG ? 5 : 8, 0, 0, 6, 8, 0, 0);
        set_vec(2, 4, 4, 0, 1, 0, 4, AVG ? 2 : 5, AVG ? 4 : 7, AVG ? 10 : 13, AVG ? 12 : 15, 5, 7, 13, 15);
        set_vec(3, 4, 4, 1, 0, 1, 4, 255, 255, 255, 255, 5, 7, 13, 15);
        set_vec(4, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_vec(5, 2, 2, 0, 0, 0, 1, AVG ? 1 : 3, 0, 0, 0, 3, 0, 0, 0);
        set_vec(6, 3, 3, 0, 0, 0, 1, AVG ? 2 : 4, 0, 0, 0, 4, 0, 0, 0);
        set_vec(7, 4, 4, 2, 0, 0, 4, AVG ? 12 : 15, AVG ? 10 : 13, AVG ? 4 : 7, AVG ? 2 : 5, 5, 7, 13, 15);

        #1;
        check("reset pool_out", int'(pool_out), 0);
        check("reset valid_out", int'(valid_out), 0);
        check("reset frame_done", int'(frame_done), 0);
        check("reset out_column_size", int'(out_column_size), 0);
        check("reset out_row_size", int'(out_row_size), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            expect_frame(i);
            send_frame(vec[i].cols, vec[i].rows, vec[i].pat, vec[i].gap, vec[i].cols * vec[i].rows);
            if (i + 1 < NV && vec[i + 1].b2b != 0) continue;
            repeat (3) @(posedge clk);
            #1;
            compare(vec[i].oc, vec[i].orr);
        end

        send_frame(4, 4, 0, 0, 6);
        rst = 1'b1;
        got_val.delete(); got_idx.delete(); got_fd.delete();
        #1;
        check("midreset pool_out", int'(pool_out), 0);
        check("midreset valid_out", int'(valid_out), 0);
        check("midreset frame_done", int'(frame_done), 0);
        check("midreset out_column_size", int'(out_column_size), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        expect_frame(0);
        send_frame(4, 4, 0, 0, 16);
        repeat (3) @(posedge clk);
        #1;
        compare(2, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
